// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake plus instruction-memory write/status port of the boot loader.
// master: the loader side; slave: the host front end / CPU side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic              start_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   word_cnt_o;

  modport master (
    input  byte_i, byte_valid_i,
    output byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
    output start_o, busy_o, done_o, err_o, word_cnt_o
  );

  modport slave (
    output byte_i, byte_valid_i,
    input  byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
    input  start_o, busy_o, done_o, err_o, word_cnt_o
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: zero-fills instruction memory, then loads a big-endian byte image
// (word-count header followed by 32-bit words) and finally releases CPU start.
module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int HDR_BYTES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  imem_boot_loader_if.master  bus
);

  localparam int HDR_W = HDR_BYTES * 8;
  localparam int HC_W  = $clog2(HDR_BYTES + 1);
  localparam logic [HC_W-1:0]  HDR_LAST = HC_W'(HDR_BYTES - 1);
  localparam logic [HDR_W-1:0] DEPTH_H  = HDR_W'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_CLEAR, S_HDR, S_DATA, S_FLUSH, S_DONE, S_ERR
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;
  logic [HC_W-1:0]   hdr_cnt;
  logic [1:0]        byte_cnt;
  logic [HDR_W-1:0]  hdr_sr;
  logic [23:0]       word_sr;
  logic [ADDR_W:0]   n_target;

  logic              accept;
  logic [HDR_W-1:0]  hdr_next;
  logic [31:0]       word_next;
  logic [ADDR_W:0]   wcnt_inc;

  assign accept    = bus.byte_valid_i & bus.byte_ready_o;
  assign hdr_next  = HDR_W'({hdr_sr, bus.byte_i});
  assign word_next = {word_sr, bus.byte_i};
  assign wcnt_inc  = bus.word_cnt_o + (ADDR_W + 1)'(1);

  // NOTE: every output is a register updated with <= in this one clocked block;
  // reset is synchronous and has priority, so a byte offered in the reset cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= S_CLEAR;
      clr_cnt          <= '0;
      hdr_cnt          <= '0;
      byte_cnt         <= '0;
      hdr_sr           <= '0;
      word_sr          <= '0;
      n_target         <= '0;
      bus.byte_ready_o <= 1'b0;
      bus.imem_we_o    <= 1'b0;
      bus.imem_addr_o  <= '0;
      bus.imem_data_o  <= '0;
      bus.start_o      <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.err_o        <= 1'b0;
      bus.word_cnt_o   <= '0;
    end else begin
      // NOTE: write enable defaults low each cycle so it pulses exactly once per word.
      bus.imem_we_o <= 1'b0;
      unique case (state)
        S_CLEAR: begin
          if (clr_cnt[ADDR_W]) begin
            state            <= S_HDR;
            clr_cnt          <= '0;
            bus.byte_ready_o <= 1'b1;
          end else begin
            bus.imem_we_o   <= 1'b1;
            bus.imem_addr_o <= clr_cnt[ADDR_W-1:0];
            bus.imem_data_o <= '0;
            bus.busy_o      <= 1'b1;
            clr_cnt         <= clr_cnt + (ADDR_W + 1)'(1);
          end
        end

        S_HDR: begin
          if (accept) begin
            hdr_sr <= hdr_next;
            if (hdr_cnt == HDR_LAST) begin
              hdr_cnt <= '0;
              if (hdr_next == '0) begin
                state            <= S_DONE;
                bus.byte_ready_o <= 1'b0;
                bus.busy_o       <= 1'b0;
                bus.start_o      <= 1'b1;
                bus.done_o       <= 1'b1;
              end else if (hdr_next > DEPTH_H) begin
                state            <= S_ERR;
                bus.byte_ready_o <= 1'b0;
                bus.busy_o       <= 1'b0;
                bus.err_o        <= 1'b1;
              end else begin
                state    <= S_DATA;
                n_target <= (ADDR_W + 1)'(hdr_next);
              end
            end else begin
              hdr_cnt <= hdr_cnt + HC_W'(1);
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            word_sr  <= word_next[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.imem_we_o   <= 1'b1;
              bus.imem_addr_o <= bus.word_cnt_o[ADDR_W-1:0];
              bus.imem_data_o <= word_next;
              bus.word_cnt_o  <= wcnt_inc;
              // Last word: stop accepting in the write cycle itself.
              if (wcnt_inc == n_target) begin
                state            <= S_FLUSH;
                bus.byte_ready_o <= 1'b0;
              end
            end
          end
        end

        S_FLUSH: begin
          state       <= S_DONE;
          bus.busy_o  <= 1'b0;
          bus.start_o <= 1'b1;
          bus.done_o  <= 1'b1;
        end

        S_DONE, S_ERR: begin
          state <= state;
        end

        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: a history-based model predicts every output from the
// reset time and the list of accepted bytes; a compare process checks each cycle.
module tb_imem_boot_loader;

  localparam int DEPTH = 256;
  localparam int HDR   = 2;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic        ready;
    logic        we;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  wcnt;
    logic [7:0]  addr;
    logic [31:0] data;
  } out_t;

  logic clk;
  logic rst;

  imem_boot_loader_if #(.ADDR_W(8)) bus ();

  imem_boot_loader #(.ADDR_W(8), .HDR_BYTES(HDR)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         since_rst  = 0;
  bit         model_live = 1'b0;
  logic [7:0] acc_q[$];
  int         edge_q[$];

  function automatic logic [31:0] model_word(int w);
    return {acc_q[HDR+4*w], acc_q[HDR+4*w+1], acc_q[HDR+4*w+2], acc_q[HDR+4*w+3]};
  endfunction

  // Expected outputs after e clock edges since the last reset edge.
  function automatic out_t model_out(int e);
    out_t o = '0;
    int n, full, e_w;
    e_w = -1;
    if (e == 0) return o;
    o.busy = 1'b1;
    if (e <= DEPTH) begin
      o.we   = 1'b1;
      o.addr = 8'(e - 1);
      return o;
    end
    if (acc_q.size() < HDR) begin
      o.ready = 1'b1;
      return o;
    end
    n = int'(acc_q[0]) * 256 + int'(acc_q[1]);
    if (n == 0) begin
      o.busy = 1'b0; o.start = 1'b1; o.done = 1'b1;
      return o;
    end
    if (n > DEPTH) begin
      o.busy = 1'b0; o.err = 1'b1;
      return o;
    end
    full   = (acc_q.size() - HDR) / 4;
    o.wcnt = 9'(full);
    if (full > 0) begin
      e_w = edge_q[HDR + 4*full - 1];
      if (e_w == e) begin
        o.we   = 1'b1;
        o.addr = 8'(full - 1);
        o.data = model_word(full - 1);
      end
    end
    if (full == n) begin
      if (e_w != e) begin
        o.busy = 1'b0; o.start = 1'b1; o.done = 1'b1;
      end
    end else begin
      o.ready = 1'b1;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      since_rst  = 0;
      acc_q.delete();
      edge_q.delete();
      model_live = 1'b1;
    end else if (model_live) begin
      out_t cur;
      cur = model_out(since_rst);
      if (bus.byte_valid_i && cur.ready) begin
        acc_q.push_back(bus.byte_i);
        edge_q.push_back(since_rst + 1);
      end
      since_rst++;
    end
  end

  // Per-cycle comparison of every meaningful output.
  always @(negedge clk) begin
    if (model_live) begin
      out_t x;
      logic [63:0] av, xv;
      x  = model_out(since_rst);
      xv = {9'd0, x.ready, x.we, x.start, x.busy, x.done, x.err, x.wcnt,
            x.we ? x.addr : 8'h0, x.we ? x.data : 32'h0};
      av = {9'd0, bus.byte_ready_o, bus.imem_we_o, bus.start_o, bus.busy_o,
            bus.done_o, bus.err_o, bus.word_cnt_o,
            x.we ? bus.imem_addr_o : 8'h0, x.we ? bus.imem_data_o : 32'h0};
      check($sformatf("cycle%0d", since_rst), av, xv);
    end
  end

  // Instruction-memory image as written by the DUT.
  logic [31:0] tb_mem[DEPTH];
  int          wr_cnt[DEPTH];
  int          data_writes  = 0;
  int          clear_writes = 0;

  always @(negedge clk) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        tb_mem[a] = '0;
        wr_cnt[a] = 0;
      end
      data_writes  = 0;
      clear_writes = 0;
    end else if (bus.imem_we_o === 1'b1) begin
      if (since_rst <= DEPTH) clear_writes++;
      else begin
        data_writes++;
        wr_cnt[bus.imem_addr_o]++;
      end
      tb_mem[bus.imem_addr_o] = bus.imem_data_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.byte_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_clear();
    repeat (DEPTH + 1) @(negedge clk);
  endtask

  task automatic settle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input byte_q_t bytes, input int gap_pct);
    int  i = 0;
    int  budget = 0;
    bit  pend = 1'b0;
    while (i < bytes.size() && budget < 8000) begin
      @(negedge clk);
      if (pend) i++;
      pend = 1'b0;
      budget++;
      if (i < bytes.size()) begin
        if (int'($urandom_range(99)) >= gap_pct) begin
          bus.byte_valid_i = 1'b1;
          bus.byte_i       = bytes[i];
          pend             = bus.byte_ready_o;
        end else begin
          bus.byte_valid_i = 1'b0;
          bus.byte_i       = 8'($urandom);
        end
      end
    end
    bus.byte_valid_i = 1'b0;
    check("send_progress", i, bytes.size());
  endtask

  task automatic idle_bytes(input int k);
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      bus.byte_valid_i = 1'b1;
      bus.byte_i       = 8'($urandom);
    end
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  function automatic int nonzero_words();
    int cnt = 0;
    for (int a = 0; a < DEPTH; a++) if (tb_mem[a] != 32'h0) cnt++;
    return cnt;
  endfunction

  byte_q_t s2 = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'h20, 8'h42, 8'h00, 8'h01};

  initial begin
    rst = 1'b1;
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: zero-fill after reset, nothing offered
    wait_clear();
    check("clear_writes", clear_writes, DEPTH);
    check("ready_after_clear", bus.byte_ready_o, 1'b1);
    check("start_after_clear", bus.start_o, 1'b0);

    // 2: two-word image back to back
    send(s2, 0);
    settle(3);
    check("model_w0", model_word(0), 32'h8C010000);
    check("model_w1", model_word(1), 32'h20420001);
    check("s2_mem0", tb_mem[0], 32'h8C010000);
    check("s2_mem1", tb_mem[1], 32'h20420001);
    check("s2_wcnt", bus.word_cnt_o, 9'd2);
    check("s2_start_done", {bus.start_o, bus.done_o, bus.byte_ready_o}, 3'b110);
    idle_bytes(8);
    check("s2_no_extra_writes", data_writes, 2);

    // 3: empty image
    do_reset();
    wait_clear();
    send('{8'h00, 8'h00}, 0);
    settle(2);
    check("n0_writes", data_writes, 0);
    check("n0_start", bus.start_o, 1'b1);

    // 4: oversize header
    do_reset();
    wait_clear();
    send('{8'h01, 8'h01}, 0);
    idle_bytes(6);
    check("err_flags", {bus.err_o, bus.start_o, bus.byte_ready_o}, 3'b100);
    check("err_mem_zero", nonzero_words(), 0);

    // 5: same image with ~50% valid gaps
    do_reset();
    wait_clear();
    send(s2, 50);
    settle(3);
    check("gap_mem0", tb_mem[0], 32'h8C010000);
    check("gap_mem1", tb_mem[1], 32'h20420001);
    check("gap_writes", data_writes, 2);

    // 6: reset after five bytes, colliding with the sixth byte's handshake
    do_reset();
    wait_clear();
    send(s2[0:4], 0);
    check("abort_no_write", data_writes, 0);
    rst = 1'b1;
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = s2[5];
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    settle(2);
    rst = 1'b0;
    wait_clear();
    check("abort_mem0_zero", tb_mem[0], 32'h0);
    send(s2, 20);
    settle(3);
    check("reload_mem0", tb_mem[0], 32'h8C010000);
    check("reload_start", bus.start_o, 1'b1);

    // Random short image
    begin
      byte_q_t img;
      int n;
      n = int'($urandom_range(8, 1));
      img = '{8'h00, 8'(n)};
      for (int k = 0; k < 4*n; k++) img.push_back(8'($urandom));
      do_reset();
      wait_clear();
      send(img, 30);
      settle(3);
      check("rnd_writes", data_writes, n);
      for (int w = 0; w < n; w++)
        check($sformatf("rnd_mem%0d", w), tb_mem[w],
              {img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]});
    end

    // Full-depth image: every address exactly once, no wrap
    begin
      byte_q_t img;
      int bad;
      img = '{8'h01, 8'h00};
      for (int k = 0; k < 4*DEPTH; k++) img.push_back(8'($urandom));
      do_reset();
      wait_clear();
      send(img, 20);
      settle(3);
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
        if (wr_cnt[a] != 1) bad++;
        if (tb_mem[a] != {img[2+4*a], img[3+4*a], img[4+4*a], img[5+4*a]}) bad++;
      end
      check("full_bad_addrs", bad, 0);
      check("full_wcnt", bus.word_cnt_o, 9'd256);
      check("full_done", bus.done_o, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Writer-side counterpart to the CPU's instruction-memory image.
- Zero-fills the CPU instruction memory, then receives a byte-stream program image over a valid/ready handshake.
- Assembles the bytes into 32-bit instruction words and writes them sequentially from word address 0.
- Releases the CPU's start input only after the whole image is written.
- Sits between the host/serial front end and the CPU's Instruction_Memory write port and start_i.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words (256).
- HDR_BYTES, 2, length of the word-count header in bytes, big-endian.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- byte_i  in  8  incoming image byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  loader accepts a byte; a transfer occurs when valid and ready are both high on a rising edge
- imem_we_o  out  1  instruction-memory write enable, one cycle per word
- imem_addr_o  out  ADDR_W  word address
- imem_data_o  out  32  word to write
- start_o  out  1  drives CPU start_i; held high once the load completes
- busy_o  out  1  high in CLEAR, HDR and DATA states
- done_o  out  1  load completed successfully
- err_o  out  1  header word count exceeds memory depth
- word_cnt_o  out  ADDR_W+1  number of words written so far

Behaviour:
- Reset (rst_i high at a clock edge):
  - All outputs are 0 and the state goes to CLEAR with the address counter at 0.
  - Reset asserted in any state, including mid-word, aborts immediately. No partial word is ever written.
- CLEAR state:
  - Runs for 2^ADDR_W cycles.
  - imem_we_o=1, imem_data_o=0, imem_addr_o counts 0..2^ADDR_W-1, one address per cycle.
  - The first clear write occurs in the first cycle after rst_i is sampled low.
  - byte_ready_o=0 throughout.
  - Then go to HDR with the address counter reset to 0.
- HDR state:
  - byte_ready_o=1. Accepts HDR_BYTES bytes, MSB first, into N.
  - After the last header byte:
    - N=0 goes to DONE.
    - N>2^ADDR_W goes to ERR.
    - Otherwise go to DATA.
- DATA state:
  - byte_ready_o=1. Bytes are shifted in MSB first, 4 per word.
  - On acceptance of the 4th byte of a word:
    - In the next cycle, imem_we_o=1, imem_addr_o=current word index, imem_data_o=assembled word.
    - word_cnt_o increments in that same cycle.
  - Acceptance of the next byte may overlap that write cycle; a one-byte-per-cycle stream runs with no stalls.
  - imem_we_o is 0 in all other DATA cycles.
  - Gaps in byte_valid_i only delay progress; no bytes are lost or duplicated.
- Completion:
  - In the cycle of the N-th word's write, byte_ready_o drops to 0.
  - The state then goes to DONE.
- DONE state:
  - start_o=1, done_o=1, busy_o=0, byte_ready_o=0.
  - Held until reset. Further bytes are ignored and never acknowledged.
- ERR state:
  - err_o=1, start_o=0, byte_ready_o=0, busy_o=0.
  - Held until reset. Memory keeps the zero fill.
- Boundary conditions:
  - N=2^ADDR_W fills every address 0..255 exactly once; the address counter does not wrap before DONE.
  - Simultaneous reset and byte handshake: reset wins and the byte is dropped.
  - byte_valid_i during CLEAR is not acknowledged.

Test Plan:
1. Release reset with no bytes -> 256 consecutive cycles of imem_we_o=1, addr 0..255, data 0; byte_ready_o=1 from cycle 256; start_o=0.
2. Stream 00 02 8C 01 00 00 20 42 00 01 back-to-back -> writes addr0=0x8C010000, addr1=0x20420001; word_cnt_o=2; start_o=done_o=1 one cycle after the addr1 write; byte_ready_o=0.
3. Header 00 00 -> no data writes after CLEAR; start_o=1 the cycle after the second header byte is accepted.
4. Header 01 01 (N=257) -> err_o=1, start_o stays 0, byte_ready_o=0; memory all zero.
5. Scenario 2 bytes with byte_valid_i randomly deasserted about 50% of cycles -> identical writes and final state; no dropped or duplicated bytes.
6. Reset asserted after 5 of the bytes in scenario 2 -> no write to addr0 with non-zero data; CLEAR restarts at addr0; start_o=0 until a full reload completes.
